// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Lets the instruction-fetch port and the data read/write ports share one
// single-port, synchronous-read 32-bit memory. Data reads are never stalled.
// Writes are posted through a 2-entry buffer. Reads that hit the buffer get the
// buffered bytes merged in. Fetch only gets the port when nothing else wants it.
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   if_req/if_addr             fetch request (held until if_valid) and word address
//   if_data/if_valid/if_stall  fetched word, its valid strobe, stall to pipeline
//   d_rd_req/d_rd_addr         data read request and word address
//   d_rd_data                  read data, one cycle after the request; held otherwise
//   d_wr_strobe/addr/data      byte enables (nonzero = write), word address, data
//   mem_en/we/addr/wdata       memory port controls
//   mem_rdata                  memory read data, one cycle after a read enable
//   wb_overflow                sticky flag: a write was dropped
//   stall_count                saturating count of cycles with if_stall=1
module unified_mem_arbiter #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_data,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              d_rd_req,
    input  logic [ADDR_W-1:0] d_rd_addr,
    output logic [31:0]       d_rd_data,
    input  logic [3:0]        d_wr_strobe,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [31:0]       d_wr_data,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              wb_overflow,
    output logic [31:0]       stall_count
);

    // Write buffer. Entry 0 is always the oldest, so a drain shifts entry 1 down.
    logic [1:0]        wb_cnt;
    logic [ADDR_W-1:0] wb_addr [2];
    logic [3:0]        wb_strb [2];
    logic [31:0]       wb_data [2];
    logic [1:0]        wb_vld;

    logic        rd_go, wr_in, buf_ne, drain, direct, fetch_go;
    logic        enq_req, drop, enq, enq_slot;
    logic [1:0]  cnt_after_drain;
    logic [3:0]  fwd_mask_nx;
    logic [31:0] fwd_data_nx;

    logic        rd_pend, if_pend;
    logic [3:0]  fwd_mask;
    logic [31:0] fwd_data;
    logic [31:0] rd_hold, if_hold;
    logic [31:0] rd_merged;
    logic        overflow_q;
    logic [31:0] stall_cnt;

    assign wb_vld = {wb_cnt == 2'd2, wb_cnt != 2'd0};

    // Every grant is gated by reset_n so the port goes quiet the moment reset asserts.
    always_comb begin
        rd_go    = reset_n & d_rd_req;
        wr_in    = reset_n & (|d_wr_strobe);
        buf_ne   = wb_cnt != 2'd0;
        drain    = reset_n & ~d_rd_req & buf_ne;
        direct   = wr_in & ~buf_ne & ~d_rd_req;
        fetch_go = reset_n & if_req & ~d_rd_req & ~buf_ne & ~wr_in;
        enq_req  = wr_in & ~direct;
        // A full buffer can still accept a write if the oldest entry leaves this cycle.
        drop     = enq_req & (wb_cnt == 2'd2) & ~drain;
        enq      = enq_req & ~drop;
        cnt_after_drain = wb_cnt - {1'b0, drain};
        enq_slot = cnt_after_drain[0];
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'h0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rd_go) begin
            mem_en   = 1'b1;
            mem_addr = d_rd_addr;
        end else if (drain) begin
            mem_en    = 1'b1;
            mem_we    = wb_strb[0];
            mem_addr  = wb_addr[0];
            mem_wdata = wb_data[0];
        end else if (direct) begin
            mem_en    = 1'b1;
            mem_we    = d_wr_strobe;
            mem_addr  = d_wr_addr;
            mem_wdata = d_wr_data;
        end else if (fetch_go) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
        end
    end

    // Forwarding compare against the buffer contents before this cycle's enqueue.
    // A write arriving with the read is therefore ordered after it. The loop runs
    // oldest first, so a newer entry's bytes override an older one's.
    always_comb begin
        fwd_mask_nx = 4'h0;
        fwd_data_nx = '0;
        for (int i = 0; i < 2; i++) begin
            if (wb_vld[i] && wb_addr[i] == d_rd_addr) begin
                for (int b = 0; b < 4; b++) begin
                    if (wb_strb[i][b]) begin
                        fwd_mask_nx[b]         = 1'b1;
                        fwd_data_nx[8*b +: 8]  = wb_data[i][8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        rd_merged = mem_rdata;
        for (int b = 0; b < 4; b++) begin
            if (fwd_mask[b]) rd_merged[8*b +: 8] = fwd_data[8*b +: 8];
        end
    end

    assign d_rd_data   = rd_pend ? rd_merged : rd_hold;
    assign if_valid    = if_pend;
    assign if_data     = if_pend ? mem_rdata : if_hold;
    assign if_stall    = ~reset_n | (if_req & ~if_pend);
    assign wb_overflow = overflow_q;
    assign stall_count = stall_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_cnt <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                wb_addr[i] <= '0;
                wb_strb[i] <= 4'h0;
                wb_data[i] <= '0;
            end
        end else begin
            if (drain) begin
                wb_addr[0] <= wb_addr[1];
                wb_strb[0] <= wb_strb[1];
                wb_data[0] <= wb_data[1];
            end
            if (enq) begin
                wb_addr[enq_slot] <= d_wr_addr;
                wb_strb[enq_slot] <= d_wr_strobe;
                wb_data[enq_slot] <= d_wr_data;
            end
            wb_cnt <= cnt_after_drain + {1'b0, enq};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend    <= 1'b0;
            if_pend    <= 1'b0;
            fwd_mask   <= 4'h0;
            fwd_data   <= '0;
            rd_hold    <= '0;
            if_hold    <= '0;
            overflow_q <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            rd_pend  <= rd_go;
            if_pend  <= fetch_go;
            fwd_mask <= fwd_mask_nx;
            fwd_data <= fwd_data_nx;
            if (rd_pend) rd_hold <= rd_merged;
            if (if_pend) if_hold <= mem_rdata;
            if (drop) overflow_q <= 1'b1;
            if (if_req && !if_pend && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter. A behavioural synchronous RAM sits on the
// memory port. The stimulus process pushes hand-computed expectations into queues:
// fetched words, read data and memory writes in the order they must occur.
// A monitor samples on the falling edge and pops/compares whenever the DUT
// presents a fetch result, a read result or a memory write.
module tb_unified_mem_arbiter;

    logic        clk;
    logic        reset_n;
    logic        if_req;
    logic [15:0] if_addr;
    logic [31:0] if_data;
    logic        if_valid;
    logic        if_stall;
    logic        d_rd_req;
    logic [15:0] d_rd_addr;
    logic [31:0] d_rd_data;
    logic [3:0]  d_wr_strobe;
    logic [15:0] d_wr_addr;
    logic [31:0] d_wr_data;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        wb_overflow;
    logic [31:0] stall_count;

    unified_mem_arbiter #(.ADDR_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_data(if_data),
        .if_valid(if_valid), .if_stall(if_stall),
        .d_rd_req(d_rd_req), .d_rd_addr(d_rd_addr), .d_rd_data(d_rd_data),
        .d_wr_strobe(d_wr_strobe), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .wb_overflow(wb_overflow), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a;
        logic [3:0]  we;
        logic [31:0] d;
    } wr_t;

    logic [31:0] exp_if [$];
    logic [31:0] exp_rd [$];
    wr_t         exp_wr [$];

    int n_checks = 0;
    int n_pass   = 0;

    // Memory model; the first clock edge (inside reset) loads the test image.
    logic [31:0] mem [0:65535];
    logic        mem_init_done = 1'b0;
    always @(posedge clk) begin
        if (!mem_init_done) begin
            mem[16'h0005] <= 32'h0000_0093;
            mem[16'h0020] <= 32'h1234_5678;
            mem[16'h0010] <= 32'h1122_3344;
            mem[16'h0001] <= 32'h0;
            mem[16'h0002] <= 32'h0;
            mem[16'h0003] <= 32'h0;
            mem[16'h0060] <= 32'h0;
            mem[16'h0061] <= 32'h0;
            mem_init_done <= 1'b1;
        end else if (mem_en) begin
            if (mem_we != 4'h0) begin
                for (int b = 0; b < 4; b++)
                    if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    // A read issued last cycle means d_rd_data is due this cycle.
    logic rd_prev;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_prev <= 1'b0;
        else          rd_prev <= d_rd_req;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (reset_n) begin
            if (if_valid) begin
                if (exp_if.size() == 0) check("if_unexpected", {31'b0, if_valid}, 32'h0);
                else check("if_data", if_data, exp_if.pop_front());
            end
            if (rd_prev) begin
                if (exp_rd.size() == 0) check("rd_unexpected", {31'b0, rd_prev}, 32'h0);
                else check("d_rd_data", d_rd_data, exp_rd.pop_front());
            end
            if (mem_en && mem_we != 4'h0) begin
                if (exp_wr.size() == 0) begin
                    check("wr_unexpected_addr", {16'h0, mem_addr}, 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("wr_addr",  {16'h0, mem_addr}, {16'h0, e.a});
                    check("wr_we",    {28'h0, mem_we},   {28'h0, e.we});
                    check("wr_wdata", mem_wdata,         e.d);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic [15:0] ra,
                         input logic [3:0] ws, input logic [15:0] wa, input logic [31:0] wd,
                         input logic ir, input logic [15:0] ia);
        d_rd_req    = rd;
        d_rd_addr   = ra;
        d_wr_strobe = ws;
        d_wr_addr   = wa;
        d_wr_data   = wd;
        if_req      = ir;
        if_addr     = ia;
    endtask

    task automatic idle();
        drive(1'b0, 16'h0, 4'h0, 16'h0, 32'h0, 1'b0, 16'h0);
    endtask

    logic [31:0] sc;

    initial begin
        reset_n = 1'b0;
        idle();
        if_req = 1'b1;
        @(posedge clk);
        #1;
        check("rst_if_stall",    {31'b0, if_stall},    32'h1);
        check("rst_mem_en",      {31'b0, mem_en},      32'h0);
        check("rst_mem_we",      {28'b0, mem_we},      32'h0);
        check("rst_if_valid",    {31'b0, if_valid},    32'h0);
        check("rst_d_rd_data",   d_rd_data,            32'h0);
        check("rst_if_data",     if_data,              32'h0);
        check("rst_wb_overflow", {31'b0, wb_overflow}, 32'h0);
        check("rst_stall_count", stall_count,          32'h0);
        @(posedge clk);
        #1;
        if_req  = 1'b0;
        reset_n = 1'b1;
        step();
        check("post_rst_stall_count", stall_count, 32'h0);

        // Fetch only; if_req held one extra cycle so the fetch is re-granted.
        drive(1'b0, 16'h0, 4'h0, 16'h0, 32'h0, 1'b1, 16'h0005);
        exp_if.push_back(32'h0000_0093);
        exp_if.push_back(32'h0000_0093);
        #1;
        check("f_mem_en",   {31'b0, mem_en},   32'h1);
        check("f_mem_addr", {16'h0, mem_addr}, 32'h5);
        check("f_if_stall", {31'b0, if_stall}, 32'h1);
        step();
        #1;
        check("f_if_stall_n1", {31'b0, if_stall}, 32'h0);
        step();
        if_req = 1'b0;
        #1;
        check("f_stall_count", stall_count, 32'h1);
        step();

        // Read and fetch in the same cycle: read wins, fetch follows.
        sc = stall_count;
        drive(1'b1, 16'h0020, 4'h0, 16'h0, 32'h0, 1'b1, 16'h0005);
        exp_rd.push_back(32'h1234_5678);
        exp_if.push_back(32'h0000_0093);
        #1;
        check("rf_mem_addr_n", {16'h0, mem_addr}, 32'h20);
        check("rf_if_stall_n", {31'b0, if_stall}, 32'h1);
        step();
        drive(1'b0, 16'h0, 4'h0, 16'h0, 32'h0, 1'b1, 16'h0005);
        #1;
        check("rf_mem_addr_n1", {16'h0, mem_addr}, 32'h5);
        check("rf_if_stall_n1", {31'b0, if_stall}, 32'h1);
        step();
        if_req = 1'b0;
        #1;
        check("rf_stall_delta", stall_count - sc, 32'h2);
        step();

        // Partial forward: strobe 0x3 over mem[0x10]=0x11223344.
        drive(1'b1, 16'h0020, 4'h3, 16'h0010, 32'hAAAA_BBBB, 1'b0, 16'h0);
        exp_rd.push_back(32'h1234_5678);
        #1;
        check("pf_not_direct", {28'b0, mem_we}, 32'h0);
        step();
        drive(1'b1, 16'h0010, 4'h0, 16'h0, 32'h0, 1'b0, 16'h0);
        exp_rd.push_back(32'h1122_BBBB);
        step();
        idle();
        exp_wr.push_back('{a: 16'h0010, we: 4'h3, d: 32'hAAAA_BBBB});
        #1;
        check("pf_drain_we",   {28'b0, mem_we},   32'h3);
        check("pf_drain_addr", {16'h0, mem_addr}, 32'h10);
        step();

        // Full forward; same-cycle write stays behind the read; newer entry overrides.
        drive(1'b1, 16'h0020, 4'hF, 16'h0010, 32'hDEAD_BEEF, 1'b0, 16'h0);
        exp_rd.push_back(32'h1234_5678);
        step();
        drive(1'b1, 16'h0010, 4'hF, 16'h0010, 32'h5555_5555, 1'b0, 16'h0);
        exp_rd.push_back(32'hDEAD_BEEF);
        step();
        drive(1'b1, 16'h0010, 4'h0, 16'h0, 32'h0, 1'b0, 16'h0);
        exp_rd.push_back(32'h5555_5555);
        step();
        idle();
        exp_wr.push_back('{a: 16'h0010, we: 4'hF, d: 32'hDEAD_BEEF});
        exp_wr.push_back('{a: 16'h0010, we: 4'hF, d: 32'h5555_5555});
        #1;
        check("ff_drain_we",   {28'b0, mem_we},   32'hF);
        check("ff_drain_addr", {16'h0, mem_addr}, 32'h10);
        step();
        step();

        // Direct write into an empty, idle port.
        drive(1'b0, 16'h0, 4'hC, 16'h0040, 32'h1234_0000, 1'b0, 16'h0);
        exp_wr.push_back('{a: 16'h0040, we: 4'hC, d: 32'h1234_0000});
        #1;
        check("dw_mem_we", {28'b0, mem_we}, 32'hC);
        step();
        idle();
        step();

        // Full buffer accepts a write in a cycle where it also drains.
        drive(1'b1, 16'h0020, 4'hF, 16'h0050, 32'h5050_5050, 1'b0, 16'h0);
        exp_rd.push_back(32'h1234_5678);
        step();
        drive(1'b1, 16'h0020, 4'hF, 16'h0051, 32'h5151_5151, 1'b0, 16'h0);
        exp_rd.push_back(32'h1234_5678);
        step();
        drive(1'b0, 16'h0, 4'hF, 16'h0052, 32'h5252_5252, 1'b0, 16'h0);
        exp_wr.push_back('{a: 16'h0050, we: 4'hF, d: 32'h5050_5050});
        exp_wr.push_back('{a: 16'h0051, we: 4'hF, d: 32'h5151_5151});
        exp_wr.push_back('{a: 16'h0052, we: 4'hF, d: 32'h5252_5252});
        step();
        idle();
        step();
        step();
        check("fd_no_overflow", {31'b0, wb_overflow}, 32'h0);

        // Overflow: third write meets a full buffer while a read holds the port.
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 16'h0020, 4'hF, 16'(i), 32'(i), 1'b0, 16'h0);
            exp_rd.push_back(32'h1234_5678);
            if (i == 3) begin
                #1;
                check("ov_before", {31'b0, wb_overflow}, 32'h0);
            end
            step();
        end
        idle();
        exp_wr.push_back('{a: 16'h0001, we: 4'hF, d: 32'h1});
        exp_wr.push_back('{a: 16'h0002, we: 4'hF, d: 32'h2});
        #1;
        check("ov_set", {31'b0, wb_overflow}, 32'h1);
        step();
        step();
        step();
        check("ov_mem1", mem[16'h0001], 32'h1);
        check("ov_mem2", mem[16'h0002], 32'h2);
        check("ov_mem3", mem[16'h0003], 32'h0);
        check("ov_sticky", {31'b0, wb_overflow}, 32'h1);

        // Reset with the buffer full: writes must vanish, port goes quiet at once.
        drive(1'b1, 16'h0020, 4'hF, 16'h0060, 32'h6060_6060, 1'b0, 16'h0);
        exp_rd.push_back(32'h1234_5678);
        step();
        drive(1'b1, 16'h0020, 4'hF, 16'h0061, 32'h6161_6161, 1'b0, 16'h0);
        exp_rd.push_back(32'h1234_5678);
        step();
        drive(1'b1, 16'h0020, 4'h0, 16'h0, 32'h0, 1'b0, 16'h0);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("mr_mem_en",      {31'b0, mem_en},      32'h0);
        check("mr_if_stall",    {31'b0, if_stall},    32'h1);
        check("mr_wb_overflow", {31'b0, wb_overflow}, 32'h0);
        check("mr_d_rd_data",   d_rd_data,            32'h0);
        idle();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("mr_stall_count", stall_count,                32'h0);
        check("mr_overflow",    {31'b0, wb_overflow},       32'h0);
        check("mr_mem60",       mem[16'h0060],              32'h0);
        check("mr_mem61",       mem[16'h0061],              32'h0);

        check("q_if_empty", 32'(exp_if.size()), 32'h0);
        check("q_rd_empty", 32'(exp_rd.size()), 32'h0);
        check("q_wr_empty", 32'(exp_wr.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
